code_lock: RTL and testbench
============================

CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 Parameter DIGIT_W, default 4, sets the bit width of one key digit.
REQ-002 Parameter NUM_DIGITS, default 4, sets the number of digits per code (min 1).
REQ-003 Parameter MAX_TRIES, default 3, sets the consecutive wrong codes allowed before lockout (min 1).
REQ-004 Parameter UNLOCK_CYCLES, default 8, sets the unlock hold time in clk cycles (min 1).
REQ-005 Parameter LOCKOUT_CYCLES, default 16, sets the lockout duration in clk cycles (min 1).
REQ-006 Parameter DEFAULT_CODE, default 16'h1234 (DIGIT_W*NUM_DIGITS bits), sets the code loaded at reset; the first digit is the MS digit.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 reset  input  1  reset is synchronous and active-high.
REQ-009 key_valid  input  1  key_data is presented this cycle.
REQ-010 key_data  input  DIGIT_W  digit value.
REQ-011 key_clear  input  1  aborts the current entry.
REQ-012 prog_req  input  1  requests code reprogramming; present only with CODE_LOCK_PROG_EN.
REQ-013 unlock  output  1  high while in UNLOCK.
REQ-014 locked_out  output  1  high while in LOCKOUT.
REQ-015 fail  output  1  one-cycle pulse on a wrong code.
REQ-016 digit_cnt  output  $clog2(NUM_DIGITS+1)  digits accepted in the current entry.
REQ-017 tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts.

Function
REQ-018 The FSM SHALL have states IDLE, ENTRY, UNLOCK, LOCKOUT and PROG; all outputs SHALL be registered or decoded from registered state only.
REQ-019 In IDLE/ENTRY a digit is accepted at an edge where key_valid=1 and key_clear=0; digit_cnt increments; IDLE->ENTRY on the first digit.
REQ-020 On the edge accepting digit NUM_DIGITS, the full entry (buffer plus incoming digit) SHALL be compared against the stored code; match -> UNLOCK, else fail=1 for the next cycle, tries_left-1, then IDLE (or LOCKOUT if tries_left reaches 0); digit_cnt returns to 0.
REQ-021 The comparison SHALL be exact over all DIGIT_W*NUM_DIGITS bits; no partial-match unlock.
REQ-022 UNLOCK SHALL last exactly UNLOCK_CYCLES cycles, then IDLE; tries_left SHALL reload to MAX_TRIES on entry to UNLOCK.
REQ-023 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then IDLE with tries_left=MAX_TRIES.
REQ-024 key_valid SHALL be ignored in UNLOCK and LOCKOUT; key_clear SHALL be ignored in UNLOCK and LOCKOUT.
REQ-025 key_clear in ENTRY SHALL discard the digits, set digit_cnt=0 and return to IDLE without consuming a try; key_clear SHALL win over a simultaneous key_valid.
REQ-026 The duration counter SHALL be sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES) and never wrap.

Reset
REQ-027 reset SHALL have priority over all inputs and, at any state including mid-entry, UNLOCK, LOCKOUT or PROG, SHALL set IDLE, unlock=0, locked_out=0, fail=0, digit_cnt=0, tries_left=MAX_TRIES, stored code=DEFAULT_CODE, entry buffer cleared.

Configuration
REQ-028 With CODE_LOCK_PROG_EN defined, prog_req=1 in UNLOCK SHALL move to PROG (unlock=0); the next NUM_DIGITS accepted digits SHALL replace the stored code on the edge accepting the last digit, then IDLE; key_clear in PROG SHALL abort to IDLE with the code unchanged; PROG has no timeout.
REQ-029 Without CODE_LOCK_PROG_EN, the prog_req port, PROG state and code-write logic SHALL be absent and the code SHALL be constant DEFAULT_CODE.

Verification (default parameters)
REQ-030 Keys 1,2,3,4 -> unlock high exactly 8 cycles starting the cycle after the 4th key, fail never high, tries_left=3.
REQ-031 Keys 1,2,3,5 -> fail one cycle, tries_left=2, unlock=0; then 1,2,3,4 -> unlock and tries_left=3.
REQ-032 Three wrong codes -> locked_out high 16 cycles; keys 1,2,3,4 during lockout ignored; afterwards tries_left=3 and 1,2,3,4 unlocks.
REQ-033 Keys 1,2 then key_clear with key_valid=1 in the same cycle -> digit_cnt=0, tries_left=3; then 1,2,3,4 unlocks.
REQ-034 (CODE_LOCK_PROG_EN) Unlock, prog_req, keys 9,8,7,6 -> IDLE; 1,2,3,4 fails; 9,8,7,6 unlocks; reset; 1,2,3,4 unlocks.
REQ-035 reset asserted after 3 digits and during LOCKOUT -> all outputs at reset values next cycle; a fresh 1,2,3,4 unlocks.

Source files
------------

// File: rtl/code_lock.sv
// rtl/code_lock.sv - digit-entry code lock with try limit, timed unlock and lockout.
// Optional CODE_LOCK_PROG_EN adds prog_req and a PROG state that rewrites the stored code.
module code_lock #(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                key_valid,
  input  logic [DIGIT_W-1:0]                  key_data,
  input  logic                                key_clear,
`ifdef CODE_LOCK_PROG_EN
  input  logic                                prog_req,
`endif
  output logic                                unlock,
  output logic                                locked_out,
  output logic                                fail,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);

  localparam int CW      = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int DUR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCK,
`ifdef CODE_LOCK_PROG_EN
    S_LOCKOUT,
    S_PROG
`else
    S_LOCKOUT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]      buf_q, buf_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               fail_q, fail_d;
  logic [CW-1:0]      code;
  logic [CW-1:0]      full_entry;
  logic               last_digit;

`ifdef CODE_LOCK_PROG_EN
  logic [CW-1:0]      code_q, code_d;
  assign code = code_q;
`else
  assign code = DEFAULT_CODE;
`endif

  // Buffered digits shifted up with the incoming digit as the LS digit.
  assign full_entry = (buf_q << DIGIT_W) | CW'(key_data);
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      dur_q   <= '0;
      fail_q  <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
      code_q  <= DEFAULT_CODE;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      tries_q <= tries_d;
      dur_q   <= dur_d;
      fail_q  <= fail_d;
`ifdef CODE_LOCK_PROG_EN
      code_q  <= code_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    tries_d = tries_q;
    dur_d   = dur_q;
    fail_d  = 1'b0;
`ifdef CODE_LOCK_PROG_EN
    code_d  = code_q;
`endif
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (key_valid) begin
          if (last_digit) begin
            cnt_d = '0;
            buf_d = '0;
            if (full_entry == code) begin
              state_d = S_UNLOCK;
              dur_d   = DUR_W'(UNLOCK_CYCLES - 1);
              tries_d = TRY_W'(MAX_TRIES);
            end else begin
              fail_d  = 1'b1;
              tries_d = tries_q - TRY_W'(1);
              if (tries_q == TRY_W'(1)) begin
                state_d = S_LOCKOUT;
                dur_d   = DUR_W'(LOCKOUT_CYCLES - 1);
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            state_d = S_ENTRY;
            cnt_d   = cnt_q + CNT_W'(1);
            buf_d   = full_entry;
          end
        end
      end
      S_UNLOCK: begin
`ifdef CODE_LOCK_PROG_EN
        if (prog_req) begin
          state_d = S_PROG;
          cnt_d   = '0;
          buf_d   = '0;
        end else
`endif
        if (dur_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (dur_q == '0) begin
          state_d = S_IDLE;
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
`ifdef CODE_LOCK_PROG_EN
      S_PROG: begin
        if (key_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (key_valid) begin
          if (last_digit) begin
            state_d = S_IDLE;
            code_d  = full_entry;
            cnt_d   = '0;
            buf_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            buf_d = full_entry;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unlock     = (state_q == S_UNLOCK);
    locked_out = (state_q == S_LOCKOUT);
    fail       = fail_q;
    digit_cnt  = cnt_q;
    tries_left = tries_q;
  end

endmodule

// File: tb/tb_code_lock.sv
// tb/tb_code_lock.sv - randomized and directed bench for code_lock against a queue-based reference model.
// Define CODE_LOCK_PROG_EN to also exercise code reprogramming.
module tb_code_lock;

  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int NUM_DIGITS     = 4;
  localparam int CODE           = 'h1234;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_data = 4'd0;
  logic       key_clear = 1'b0;
`ifdef CODE_LOCK_PROG_EN
  logic       prog_req = 1'b0;
`endif
  logic       unlock, locked_out, fail;
  logic [2:0] digit_cnt;
  logic [1:0] tries_left;

  int checks = 0;
  int failures = 0;

  int m_q[$];
  int m_tries = MAX_TRIES;
  int m_unlock_rem = 0;
  int m_lock_rem = 0;
  bit m_fail = 1'b0;

  code_lock dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .key_clear  (key_clear),
`ifdef CODE_LOCK_PROG_EN
    .prog_req   (prog_req),
`endif
    .unlock     (unlock),
    .locked_out (locked_out),
    .fail       (fail),
    .digit_cnt  (digit_cnt),
    .tries_left (tries_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int code_digit(input int idx);
    int c;
    c = CODE;
    return (c >> (4 * (NUM_DIGITS - 1 - idx))) & 'hF;
  endfunction

  // Reference: digits collected in a queue, timers count remaining cycles.
  task automatic model_step(input logic kv, input logic [3:0] kd, input logic kc, input logic rst);
    int v;
    if (rst) begin
      m_q.delete();
      m_tries      = MAX_TRIES;
      m_unlock_rem = 0;
      m_lock_rem   = 0;
      m_fail       = 1'b0;
    end else begin
      m_fail = 1'b0;
      if (m_unlock_rem > 0) begin
        m_unlock_rem--;
      end else if (m_lock_rem > 0) begin
        m_lock_rem--;
        if (m_lock_rem == 0) m_tries = MAX_TRIES;
      end else if (kc) begin
        m_q.delete();
      end else if (kv) begin
        m_q.push_back(int'(kd));
        if (m_q.size() == NUM_DIGITS) begin
          v = 0;
          foreach (m_q[i]) v = v * 16 + m_q[i];
          if (v == CODE) begin
            m_unlock_rem = UNLOCK_CYCLES;
            m_tries      = MAX_TRIES;
          end else begin
            m_fail = 1'b1;
            m_tries--;
            if (m_tries == 0) m_lock_rem = LOCKOUT_CYCLES;
          end
          m_q.delete();
        end
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    return {m_unlock_rem > 0, m_lock_rem > 0, m_fail, 3'(m_q.size()), 2'(m_tries)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {unlock, locked_out, fail, digit_cnt, tries_left};
  endfunction

  task automatic drive(input logic kv, input logic [3:0] kd, input logic kc, input logic rst);
    key_valid = kv;
    key_data  = kd;
    key_clear = kc;
    reset     = rst;
    @(posedge clk);
    model_step(kv, kd, kc, rst);
    @(negedge clk);
    key_valid = 1'b0;
    key_clear = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd1, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== 8'b000_000_11) begin
        failures++;
        $display("FAIL reset_state got=%b exp=%b", dut_vec(), 8'b00000011);
      end
    end
  endtask

  task automatic test_correct_code();
    int ucount = 0;
    bit fail_seen = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL correct_code_key%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (unlock) ucount++;
      if (fail) fail_seen = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      if (unlock) ucount++;
      if (fail) fail_seen = 1'b1;
    end
    checks++;
    if (ucount !== UNLOCK_CYCLES) begin
      failures++;
      $display("FAIL unlock_duration got=%0d exp=%0d", ucount, UNLOCK_CYCLES);
    end
    checks++;
    if (fail_seen !== 1'b0 || tries_left !== 2'd3) begin
      failures++;
      $display("FAIL correct_code_flags got fail_seen=%0b tries=%0d exp fail_seen=0 tries=3", fail_seen, tries_left);
    end
  endtask

  task automatic test_wrong_then_right();
    int keys[4];
    keys = '{1, 2, 3, 5};
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(keys[i]), 1'b0, 1'b0);
    checks++;
    if ({fail, tries_left, unlock} !== {1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL wrong_code got fail=%0b tries=%0d unlock=%0b exp 1 2 0", fail, tries_left, unlock);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (fail !== 1'b0) begin
      failures++;
      $display("FAIL fail_pulse_width got=%0b exp=0", fail);
    end
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if ({unlock, tries_left} !== {1'b1, 2'd3}) begin
      failures++;
      $display("FAIL retry_unlock got unlock=%0b tries=%0d exp 1 3", unlock, tries_left);
    end
    for (int i = 0; i < UNLOCK_CYCLES; i++) drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_lockout();
    int lcount = 1;
    for (int t = 0; t < MAX_TRIES; t++)
      for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'd5, 1'b0, 1'b0);
    checks++;
    if ({locked_out, tries_left, fail} !== {1'b1, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL lockout_entry got lo=%0b tries=%0d fail=%0b exp 1 0 1", locked_out, tries_left, fail);
    end
    for (int i = 0; i < 20; i++) begin
      if (i < NUM_DIGITS) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
      else drive(1'b0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL lockout_cycle%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (locked_out) lcount++;
    end
    checks++;
    if (lcount !== LOCKOUT_CYCLES || tries_left !== 2'd3 || unlock !== 1'b0) begin
      failures++;
      $display("FAIL lockout_duration got cycles=%0d tries=%0d unlock=%0b exp %0d 3 0", lcount, tries_left, unlock, LOCKOUT_CYCLES);
    end
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL post_lockout_unlock got=%0b exp=1", unlock);
    end
    for (int i = 0; i < UNLOCK_CYCLES; i++) drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b1, 1'b0);
    checks++;
    if ({digit_cnt, tries_left, fail, unlock} !== {3'd0, 2'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_wins got cnt=%0d tries=%0d fail=%0b unlock=%0b exp 0 3 0 0", digit_cnt, tries_left, fail, unlock);
    end
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL clear_then_unlock got=%0b exp=1", unlock);
    end
    // key_clear during UNLOCK must not end it early
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL clear_ignored_in_unlock got=%0b exp=1", unlock);
    end
    for (int i = 0; i < UNLOCK_CYCLES; i++) drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 8'b00000011) begin
      failures++;
      $display("FAIL reset_mid_entry got=%b exp=%b", dut_vec(), 8'b00000011);
    end
    for (int t = 0; t < MAX_TRIES; t++)
      for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 8'b00000011) begin
      failures++;
      $display("FAIL reset_in_lockout got=%b exp=%b", dut_vec(), 8'b00000011);
    end
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL unlock_after_reset got=%0b exp=1", unlock);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 8'b00000011) begin
      failures++;
      $display("FAIL reset_in_unlock got=%b exp=%b", dut_vec(), 8'b00000011);
    end
  endtask

`ifdef CODE_LOCK_PROG_EN
  task automatic test_prog();
    int newc[4];
    newc = '{9, 8, 7, 6};
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    prog_req = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    prog_req = 1'b0;
    checks++;
    if (unlock !== 1'b0) begin
      failures++;
      $display("FAIL prog_entry_unlock got=%0b exp=0", unlock);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(newc[i]), 1'b0, 1'b0);
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if ({fail, unlock} !== 2'b10) begin
      failures++;
      $display("FAIL prog_old_code got fail=%0b unlock=%0b exp 1 0", fail, unlock);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(newc[i]), 1'b0, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL prog_new_code got=%0b exp=1", unlock);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < NUM_DIGITS; i++) drive(1'b1, 4'(code_digit(i)), 1'b0, 1'b0);
    checks++;
    if (unlock !== 1'b1) begin
      failures++;
      $display("FAIL prog_reset_restores got=%0b exp=1", unlock);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic       kv, kc, rst;
    logic [3:0] kd;
    int         errs = 0;
    for (int n = 0; n < 3000; n++) begin
      kv  = ($urandom_range(99, 0) < 60);
      kc  = ($urandom_range(99, 0) < 5);
      rst = ($urandom_range(999, 0) < 5);
      if ($urandom_range(1, 0) == 1 && m_q.size() < NUM_DIGITS)
        kd = 4'(code_digit(m_q.size()));
      else
        kd = 4'($urandom_range(15, 0));
      drive(kv, kd, kc, rst);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_correct_code();
    test_wrong_then_right();
    test_lockout();
    test_clear();
    test_reset_midway();
`ifdef CODE_LOCK_PROG_EN
    test_prog();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
